ramctrl: RTL
============

# ramctrl

Arbitrates the single byte-wide RAM/IO port between the instruction fetch unit and datactrl. Serialises each 1/2/4-byte request into consecutive byte accesses. Assembles read data little-endian with optional sign extension. Holds I/O writes while the host UART buffer is full.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all address ports.
- IO_SEL, 2'b11, value of addr[17:16] that marks the I/O region.

Ports:
- clk_in  in  1  clock; all state changes on rising edge.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- io_buffer_full_in  in  1  UART buffer full.
- icache_ramctrl_en_in  in  1  instruction fetch request; level, held until rdy.
- icache_ramctrl_addr_in  in  ADDR_WIDTH  fetch address; always 4 bytes.
- ramctrl_icache_rdy_out  out  1  one-cycle done pulse.
- ramctrl_icache_data_out  out  32  fetched word; valid while rdy is high.
- datactrl_ramctrl_data_en_in  in  1  data request; level, held until rdy.
- datactrl_ramctrl_data_rw_in  in  1  1 = write, 0 = read.
- datactrl_ramctrl_data_sgn_in  in  1  1 = sign-extend the read result.
- datactrl_ramctrl_data_width_in  in  3  001 = byte, 010 = half, 100 = word; any other value is treated as byte.
- datactrl_ramctrl_data_addr_in  in  ADDR_WIDTH  byte address.
- datactrl_ramctrl_data_data_in  in  32  write data; low bytes are used.
- ramctrl_datactrl_data_rdy_out  out  1  one-cycle done pulse.
- ramctrl_datactrl_data_data_out  out  32  read result; valid while rdy is high.
- mem_din  in  8  RAM read byte; valid the cycle after mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  write strobe; gated: registered strobe AND rdy_in.

## Operation
- FSM states:
  - IDLE: no transaction.
  - IOWAIT: I/O write held for a non-full UART buffer.
  - RD: read in progress.
  - WR: write in progress.
  - DONE: done pulse.
- Counter cnt[2:0] tracks the byte index. Length N is 4 for fetch and decoded from width for data.
- Arbitration happens in IDLE only, round-robin on the last_grant bit.
  - If both requests are pending, the requester not granted last wins.
  - last_grant resets to instruction, so data wins the first tie.
  - A lone request is always granted.
- Read: mem_a = addr+k for k = 0..N-1. Byte k from mem_din goes to result bits [8k+7:8k].
  - sgn=1: bits above 8N-1 are copied from bit 8N-1.
  - sgn=0: bits above 8N-1 are zero.
  - Fetch results are never extended.
- Write: mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1, for k = 0..N-1.
- I/O write (addr[17:16] == IO_SEL and rw=1): enter IOWAIT and stay while io_buffer_full_in is high, then proceed as WR.
  - I/O reads are not held.
- DONE: pulse the granted requester's rdy for one cycle, drive mem_wr = 0, return to IDLE. Requests are not sampled in DONE.
- Address arithmetic wraps at ADDR_WIDTH.

## Timing
- Request accepted in cycle T (state IDLE, en high, rdy_in high).
- Read: mem_a = addr+k in cycle T+1+k. Byte k is captured at the end of cycle T+2+k. rdy and data are valid in cycle T+2+N.
  - Word read: rdy in T+6.
- Write: byte k is driven in cycle T+1+k. rdy in T+1+N.
  - IOWAIT adds one cycle per full cycle plus one cycle to exit.
- Next acceptance is possible at the earliest one cycle after rdy.
- Requester deasserts en in the rdy cycle. A still-high en the next cycle is a new request.
- rdy_in low: state, cnt, mem_a and the partial result hold; mem_wr forced 0. On resume, the sequence continues unchanged.
- Reset values (rst_in low at an edge): state IDLE, cnt 0, last_grant instruction, and all outputs 0.
  - Reset mid-transaction aborts with no rdy pulse and no further mem_wr.

## Structure
- Shared in constant.vh: AddressWidth, width codes (BYTE/HALF/WORD), IO_SEL, state encodings.
- Single module; the arbiter is a few lines and gets no sub-module.

## Test plan
- Fetch, addr 0x100, RAM bytes 13 05 00 00 -> mem_a runs 0x100–0x103 in T+1..T+4; icache rdy in T+6 with data 0x00000513.
- Data read, byte, sgn=1, addr 0x20, RAM 0x80 -> data rdy in T+3, data 0xFFFFFF80. Same with sgn=0 -> 0x00000080.
- Data write, half, addr 0x40, data 0x1234ABCD -> mem_wr=1 with (0x40, CD) in T+1 and (0x41, AB) in T+2; rdy in T+3.
- Fetch and data raised in the same cycle after reset -> data granted first. Fetch is granted one cycle after data rdy. A repeated data request waits until fetch rdy.
- Byte write to 0x30000 with io_buffer_full_in high for 3 cycles -> no mem_wr while full; single mem_wr with dout = data[7:0] after release.
- rst_in low in T+3 of a word read -> no rdy; mem_wr 0; IDLE next cycle. rdy_in low for 2 cycles mid-write -> mem_wr 0 during the pause; the full sequence finishes 2 cycles late.

Source files
------------

// File: rtl/ramctrl_pkg.sv
// Shared types, width codes and byte-lane helpers for the RAM/IO port controller.
package ramctrl_pkg;

    localparam int         ADDR_WIDTH_DEF = 32;
    localparam logic [1:0] IO_SEL_DEF     = 2'b11;

    localparam logic [2:0] WIDTH_BYTE = 3'b001;
    localparam logic [2:0] WIDTH_HALF = 3'b010;
    localparam logic [2:0] WIDTH_WORD = 3'b100;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IOWAIT = 3'd1,
        ST_RD     = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Unknown width codes fall back to a single byte.
    function automatic logic [2:0] width_to_len(input logic [2:0] w);
        case (w)
            WIDTH_HALF: return 3'd2;
            WIDTH_WORD: return 3'd4;
            default:    return 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Fill the bits above the last assembled byte with its MSB (sgn) or zero.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                           input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (n)
            3'd1:    return sgn ? 32'(b) : {24'd0, w[7:0]};
            3'd2:    return sgn ? 32'(h) : {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/ramctrl_if.sv
// Request/response and byte-wide memory signals shared by fetch, datactrl and RAM.
interface ramctrl_if #(parameter int ADDR_WIDTH = 32);

    logic                  icache_ramctrl_en_in;
    logic [ADDR_WIDTH-1:0] icache_ramctrl_addr_in;
    logic                  ramctrl_icache_rdy_out;
    logic [31:0]           ramctrl_icache_data_out;

    logic                  datactrl_ramctrl_data_en_in;
    logic                  datactrl_ramctrl_data_rw_in;
    logic                  datactrl_ramctrl_data_sgn_in;
    logic [2:0]            datactrl_ramctrl_data_width_in;
    logic [ADDR_WIDTH-1:0] datactrl_ramctrl_data_addr_in;
    logic [31:0]           datactrl_ramctrl_data_data_in;
    logic                  ramctrl_datactrl_data_rdy_out;
    logic [31:0]           ramctrl_datactrl_data_data_out;

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    modport slave (
        input  icache_ramctrl_en_in, icache_ramctrl_addr_in,
        output ramctrl_icache_rdy_out, ramctrl_icache_data_out,
        input  datactrl_ramctrl_data_en_in, datactrl_ramctrl_data_rw_in,
        input  datactrl_ramctrl_data_sgn_in, datactrl_ramctrl_data_width_in,
        input  datactrl_ramctrl_data_addr_in, datactrl_ramctrl_data_data_in,
        output ramctrl_datactrl_data_rdy_out, ramctrl_datactrl_data_data_out,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output icache_ramctrl_en_in, icache_ramctrl_addr_in,
        input  ramctrl_icache_rdy_out, ramctrl_icache_data_out,
        output datactrl_ramctrl_data_en_in, datactrl_ramctrl_data_rw_in,
        output datactrl_ramctrl_data_sgn_in, datactrl_ramctrl_data_width_in,
        output datactrl_ramctrl_data_addr_in, datactrl_ramctrl_data_data_in,
        input  ramctrl_datactrl_data_rdy_out, ramctrl_datactrl_data_data_out,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/ramctrl.sv
// Arbitrates the byte-wide RAM/IO port between instruction fetch and datactrl,
// serialising 1/2/4-byte requests into consecutive byte accesses.
module ramctrl
    import ramctrl_pkg::*;
#(
    parameter int         ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [1:0] IO_SEL     = IO_SEL_DEF
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      io_buffer_full_in,
    ramctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [31:0]           result_q, result_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            n_q, n_d;
    logic                  sgn_q, sgn_d;

    logic fetch_req, data_req, data_is_io, pick_data;

    assign fetch_req  = bus.icache_ramctrl_en_in;
    assign data_req   = bus.datactrl_ramctrl_data_en_in;
    assign data_is_io = (bus.datactrl_ramctrl_data_addr_in[17:16] == IO_SEL);
    // Round-robin: on a tie the side not granted last time wins.
    assign pick_data  = data_req && (!fetch_req || last_grant_q == GRANT_INST);

    // Next-state and datapath: arbitration in IDLE, then byte-serial read/write.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        result_d     = result_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        n_d          = n_q;
        sgn_d        = sgn_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_data) begin
                    grant_d      = GRANT_DATA;
                    last_grant_d = GRANT_DATA;
                    addr_d       = bus.datactrl_ramctrl_data_addr_in;
                    wdata_d      = bus.datactrl_ramctrl_data_data_in;
                    n_d          = width_to_len(bus.datactrl_ramctrl_data_width_in);
                    sgn_d        = bus.datactrl_ramctrl_data_sgn_in;
                    cnt_d        = 3'd0;
                    result_d     = 32'd0;
                    if (!bus.datactrl_ramctrl_data_rw_in) begin
                        state_d = ST_RD;
                        mem_a_d = bus.datactrl_ramctrl_data_addr_in;
                    end else if (data_is_io) begin
                        state_d = ST_IOWAIT;
                    end else begin
                        state_d    = ST_WR;
                        mem_a_d    = bus.datactrl_ramctrl_data_addr_in;
                        mem_dout_d = bus.datactrl_ramctrl_data_data_in[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else if (fetch_req) begin
                    grant_d      = GRANT_INST;
                    last_grant_d = GRANT_INST;
                    addr_d       = bus.icache_ramctrl_addr_in;
                    n_d          = 3'd4;
                    sgn_d        = 1'b0;
                    cnt_d        = 3'd0;
                    result_d     = 32'd0;
                    state_d      = ST_RD;
                    mem_a_d      = bus.icache_ramctrl_addr_in;
                end
            end
            ST_IOWAIT: begin
                if (!io_buffer_full_in) begin
                    state_d    = ST_WR;
                    mem_a_d    = addr_q;
                    mem_dout_d = wdata_q[7:0];
                    mem_wr_d   = 1'b1;
                end
            end
            ST_RD: begin
                // mem_din carries the byte addressed in the previous cycle.
                if (cnt_q != 3'd0) begin
                    result_d = byte_put(result_q, cnt_q[1:0] - 2'd1, bus.mem_din);
                end
                if (cnt_q == n_q) begin
                    result_d = extend(result_d, n_q, sgn_q);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 < n_q) begin
                        mem_a_d = mem_a_q + ADDR_ONE;
                    end
                end
            end
            ST_WR: begin
                if (cnt_q == n_q - 3'd1) begin
                    state_d  = ST_DONE;
                    mem_wr_d = 1'b0;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_a_d    = mem_a_q + ADDR_ONE;
                    mem_dout_d = byte_sel(wdata_q, cnt_q[1:0] + 2'd1);
                    mem_wr_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                cnt_d    = 3'd0;
                mem_wr_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= GRANT_INST;
            grant_q      <= GRANT_INST;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            result_q     <= 32'd0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            result_q     <= result_d;
        end
    end

    // Latched request context; only meaningful once a request is granted.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            n_q     <= n_d;
            sgn_q   <= sgn_d;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q & rdy_in & rst_in;

    assign bus.ramctrl_icache_rdy_out         = (state_q == ST_DONE) && (grant_q == GRANT_INST) && rdy_in;
    assign bus.ramctrl_datactrl_data_rdy_out  = (state_q == ST_DONE) && (grant_q == GRANT_DATA) && rdy_in;
    assign bus.ramctrl_icache_data_out        = result_q;
    assign bus.ramctrl_datactrl_data_data_out = result_q;

endmodule
